// File: rtl/alu_issue_queue.sv
// alu_issue_queue: out-of-order issue queue for the two integer ALUs.
// Entries wait for both source operands (captured from two result buses),
// then up to two ready entries issue per cycle, oldest first.
module alu_issue_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [3:0]         disp_optype,
    input  logic [TAG_W-1:0]   disp_rs1_tag,
    input  logic [TAG_W-1:0]   disp_rs2_tag,
    input  logic               disp_rs1_rdy,
    input  logic               disp_rs2_rdy,
    input  logic [31:0]        disp_rs1_data,
    input  logic [31:0]        disp_rs2_data,
    input  logic [31:0]        disp_imm,
    input  logic [TAG_W-1:0]   disp_rd_tag,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [31:0]        cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [31:0]        cdb1_data,
    input  logic [1:0]         fu_ready,
    output logic [1:0]         alu_number,
    output logic [3:0]         iss0_optype,
    output logic [31:0]        iss0_sr1,
    output logic [31:0]        iss0_sr2,
    output logic [31:0]        iss0_imm,
    output logic [TAG_W-1:0]   iss0_rd_tag,
    output logic [3:0]         iss1_optype,
    output logic [31:0]        iss1_sr1,
    output logic [31:0]        iss1_sr2,
    output logic [31:0]        iss1_imm,
    output logic [TAG_W-1:0]   iss1_rd_tag,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] valid, rdy1, rdy2, elig, iss_mask;
    logic [3:0]       optype [DEPTH];
    logic [TAG_W-1:0] tag1 [DEPTH], tag2 [DEPTH], rd_tag [DEPTH];
    logic [31:0]      data1 [DEPTH], data2 [DEPTH], imm [DEPTH];
    // older[i][j] = 1 when entry j was allocated before entry i
    logic [DEPTH-1:0] older [DEPTH];
    logic [OW-1:0]    rank [DEPTH];
    logic [32:0]      wk1 [DEPTH], wk2 [DEPTH];
    logic [32:0]      byp1, byp2;
    logic [IW-1:0]    alloc_idx, first_idx, second_idx, sel0_idx, sel1_idx;
    logic             first_v, second_v, sel0_v, sel1_v, disp_fire;

    // Operand capture: a not-ready source grabs a matching broadcast, cdb0 first
    function automatic logic [32:0] wake(input logic rdy, input logic [TAG_W-1:0] tag,
                                         input logic [31:0] data);
        if (!rdy && cdb0_valid && cdb0_tag == tag) return {1'b1, cdb0_data};
        if (!rdy && cdb1_valid && cdb1_tag == tag) return {1'b1, cdb1_data};
        return {rdy, data};
    endfunction

    function automatic logic [OW-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [OW-1:0] c;
        c = '0;
        for (int k = 0; k < DEPTH; k++) c = c + OW'(v[k]);
        return c;
    endfunction

    assign elig       = valid & rdy1 & rdy2;
    assign disp_ready = occupancy < OW'(DEPTH);
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign byp1       = wake(disp_rs1_rdy, disp_rs1_tag, disp_rs1_data);
    assign byp2       = wake(disp_rs2_rdy, disp_rs2_tag, disp_rs2_data);

    // Per-entry wakeup values and age rank among eligible entries
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i]  = wake(rdy1[i], tag1[i], data1[i]);
            wk2[i]  = wake(rdy2[i], tag2[i], data2[i]);
            rank[i] = popcnt(elig & older[i]);
        end
    end

    // Lowest free slot for dispatch; oldest and second-oldest eligible entries
    always_comb begin
        alloc_idx  = '0;
        first_v    = 1'b0;
        first_idx  = '0;
        second_v   = 1'b0;
        second_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid[i]) alloc_idx = IW'(i);
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && rank[i] == '0) begin
                first_v   = 1'b1;
                first_idx = IW'(i);
            end
            if (elig[i] && rank[i] == OW'(1)) begin
                second_v   = 1'b1;
                second_idx = IW'(i);
            end
        end
    end

    // Map the age-ordered picks onto whichever ALUs are ready
    always_comb begin
        sel0_v   = 1'b0;
        sel0_idx = first_idx;
        sel1_v   = 1'b0;
        sel1_idx = second_idx;
        case (fu_ready)
            2'b11: begin
                sel0_v = first_v;
                sel1_v = second_v;
            end
            2'b01: sel0_v = first_v;
            2'b10: begin
                sel1_v   = first_v;
                sel1_idx = first_idx;
            end
            default: ;
        endcase
        iss_mask = '0;
        if (sel0_v) iss_mask[sel0_idx] = 1'b1;
        if (sel1_v) iss_mask[sel1_idx] = 1'b1;
    end

    // Entry storage: wakeup, free on issue, allocate on dispatch, flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
            rdy1  <= '0;
            rdy2  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                optype[i] <= '0;
                tag1[i]   <= '0;
                tag2[i]   <= '0;
                rd_tag[i] <= '0;
                data1[i]  <= '0;
                data2[i]  <= '0;
                imm[i]    <= '0;
                older[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                {rdy1[i], data1[i]} <= wk1[i];
                {rdy2[i], data2[i]} <= wk2[i];
                if (iss_mask[i]) valid[i] <= 1'b0;
                if (disp_fire && alloc_idx == IW'(i)) begin
                    valid[i]            <= 1'b1;
                    optype[i]           <= disp_optype;
                    tag1[i]             <= disp_rs1_tag;
                    tag2[i]             <= disp_rs2_tag;
                    rd_tag[i]           <= disp_rd_tag;
                    imm[i]              <= disp_imm;
                    {rdy1[i], data1[i]} <= byp1;
                    {rdy2[i], data2[i]} <= byp2;
                    // every entry valid now is older than the newcomer
                    older[i]            <= valid;
                end else if (disp_fire) begin
                    older[i][alloc_idx] <= 1'b0;
                end
                if (flush) valid[i] <= 1'b0;
            end
        end
    end

    // Valid-entry count: +1 per dispatch, -1 per issued entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      occupancy <= '0;
        else if (flush) occupancy <= '0;
        else            occupancy <= occupancy + OW'(disp_fire) - OW'(sel0_v) - OW'(sel1_v);
    end

    // Registered issue ports, one cycle after selection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_number  <= '0;
            iss0_optype <= '0;
            iss0_sr1    <= '0;
            iss0_sr2    <= '0;
            iss0_imm    <= '0;
            iss0_rd_tag <= '0;
            iss1_optype <= '0;
            iss1_sr1    <= '0;
            iss1_sr2    <= '0;
            iss1_imm    <= '0;
            iss1_rd_tag <= '0;
        end else begin
            alu_number <= flush ? 2'b00 : {sel1_v, sel0_v};
            if (sel0_v) begin
                iss0_optype <= optype[sel0_idx];
                iss0_sr1    <= data1[sel0_idx];
                iss0_sr2    <= data2[sel0_idx];
                iss0_imm    <= imm[sel0_idx];
                iss0_rd_tag <= rd_tag[sel0_idx];
            end
            if (sel1_v) begin
                iss1_optype <= optype[sel1_idx];
                iss1_sr1    <= data1[sel1_idx];
                iss1_sr2    <= data2[sel1_idx];
                iss1_imm    <= imm[sel1_idx];
                iss1_rd_tag <= rd_tag[sel1_idx];
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: an age-ordered queue model predicts
// each issue (cycle, ALU, payload); a negedge monitor compares DUT issues.
module tb_alu_issue_queue;
    localparam int DEPTH = 8;
    localparam int TAG_W = 6;

    logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic disp_valid = 1'b0, disp_ready;
    logic [3:0] disp_optype = '0;
    logic [TAG_W-1:0] disp_rs1_tag = '0, disp_rs2_tag = '0, disp_rd_tag = '0;
    logic disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
    logic [31:0] disp_rs1_data = '0, disp_rs2_data = '0, disp_imm = '0;
    logic cdb0_valid = 1'b0, cdb1_valid = 1'b0;
    logic [TAG_W-1:0] cdb0_tag = '0, cdb1_tag = '0;
    logic [31:0] cdb0_data = '0, cdb1_data = '0;
    logic [1:0] fu_ready = 2'b11, alu_number;
    logic [3:0] iss0_optype, iss1_optype;
    logic [31:0] iss0_sr1, iss0_sr2, iss0_imm, iss1_sr1, iss1_sr2, iss1_imm;
    logic [TAG_W-1:0] iss0_rd_tag, iss1_rd_tag;
    logic [3:0] occupancy;

    int checks = 0, failures = 0, cyc = 0;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_optype(disp_optype),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_imm(disp_imm), .disp_rd_tag(disp_rd_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .fu_ready(fu_ready), .alu_number(alu_number),
        .iss0_optype(iss0_optype), .iss0_sr1(iss0_sr1), .iss0_sr2(iss0_sr2),
        .iss0_imm(iss0_imm), .iss0_rd_tag(iss0_rd_tag),
        .iss1_optype(iss1_optype), .iss1_sr1(iss1_sr1), .iss1_sr2(iss1_sr2),
        .iss1_imm(iss1_imm), .iss1_rd_tag(iss1_rd_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] op;
        logic [TAG_W-1:0] t1, t2, rd;
        logic r1, r2;
        logic [31:0] d1, d2, imm;
    } ent_t;

    typedef struct packed {
        int cyc;
        logic [3:0] op;
        logic [31:0] s1, s2, imm;
        logic [TAG_W-1:0] rd;
    } exp_t;

    ent_t mq[$];          // model entries, oldest at the front
    exp_t q0[$], q1[$];   // expected issues per ALU

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic ent_t wake(input ent_t x);
        if (!x.r1 && cdb0_valid && cdb0_tag == x.t1) begin x.r1 = 1'b1; x.d1 = cdb0_data; end
        else if (!x.r1 && cdb1_valid && cdb1_tag == x.t1) begin x.r1 = 1'b1; x.d1 = cdb1_data; end
        if (!x.r2 && cdb0_valid && cdb0_tag == x.t2) begin x.r2 = 1'b1; x.d2 = cdb0_data; end
        else if (!x.r2 && cdb1_valid && cdb1_tag == x.t2) begin x.r2 = 1'b1; x.d2 = cdb1_data; end
        return x;
    endfunction

    function automatic exp_t mk(input ent_t x);
        exp_t r;
        r.cyc = cyc + 1; r.op = x.op; r.s1 = x.d1; r.s2 = x.d2; r.imm = x.imm; r.rd = x.rd;
        return r;
    endfunction

    // Reference: one clock edge applied to the age-ordered entry list
    task automatic model_step();
        int first, second, a0, a1;
        bit can_disp;
        ent_t n;
        if (flush) begin mq.delete(); return; end
        can_disp = mq.size() < DEPTH;
        first = -1; second = -1;
        foreach (mq[i]) if (mq[i].r1 && mq[i].r2) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
        end
        a0 = -1; a1 = -1;
        if (fu_ready == 2'b11) begin a0 = first; a1 = second; end
        else if (fu_ready == 2'b01) a0 = first;
        else if (fu_ready == 2'b10) a1 = first;
        if (a0 >= 0) q0.push_back(mk(mq[a0]));
        if (a1 >= 0) q1.push_back(mk(mq[a1]));
        if (a0 > a1) begin mq.delete(a0); if (a1 >= 0) mq.delete(a1); end
        else if (a1 >= 0) begin mq.delete(a1); if (a0 >= 0) mq.delete(a0); end
        foreach (mq[i]) mq[i] = wake(mq[i]);
        if (disp_valid && can_disp) begin
            n.op = disp_optype; n.t1 = disp_rs1_tag; n.t2 = disp_rs2_tag; n.rd = disp_rd_tag;
            n.r1 = disp_rs1_rdy; n.r2 = disp_rs2_rdy; n.d1 = disp_rs1_data; n.d2 = disp_rs2_data;
            n.imm = disp_imm;
            mq.push_back(wake(n));
        end
    endtask

    // Check registered state, advance model and DUT by one edge, clear pulses
    task automatic tick();
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
        model_step();
        @(negedge clk);
        disp_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic r1, input logic [TAG_W-1:0] t1,
                        input logic [31:0] d1, input logic r2, input logic [TAG_W-1:0] t2,
                        input logic [31:0] d2);
        disp_valid = 1'b1; disp_optype = op;
        disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_data = d1;
        disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_data = d2;
        disp_imm = $urandom; disp_rd_tag = TAG_W'($urandom);
    endtask

    task automatic cdb(input int which, input logic [TAG_W-1:0] t, input logic [31:0] d);
        if (which == 0) begin cdb0_valid = 1'b1; cdb0_tag = t; cdb0_data = d; end
        else begin cdb1_valid = 1'b1; cdb1_tag = t; cdb1_data = d; end
    endtask

    // Monitor: each DUT issue must match the front of that ALU's queue in cycle and payload
    exp_t me;
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].cyc < cyc) begin
            me = q0.pop_front(); checks++; failures++;
            $display("FAIL alu0_missing cycle=%0d got=none exp_op=%0d", me.cyc, me.op);
        end
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            me = q0.pop_front(); checks++;
            if (!alu_number[0] || {iss0_optype, iss0_sr1, iss0_sr2, iss0_imm, iss0_rd_tag}
                    !== {me.op, me.s1, me.s2, me.imm, me.rd}) begin
                failures++;
                $display("FAIL alu0_issue cyc=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", cyc,
                         alu_number[0], iss0_optype, iss0_sr1, iss0_sr2, me.op, me.s1, me.s2);
            end
        end else if (alu_number[0]) begin
            checks++; failures++;
            $display("FAIL alu0_unexpected cyc=%0d got=1 exp=0", cyc);
        end
        while (q1.size() > 0 && q1[0].cyc < cyc) begin
            me = q1.pop_front(); checks++; failures++;
            $display("FAIL alu1_missing cycle=%0d got=none exp_op=%0d", me.cyc, me.op);
        end
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            me = q1.pop_front(); checks++;
            if (!alu_number[1] || {iss1_optype, iss1_sr1, iss1_sr2, iss1_imm, iss1_rd_tag}
                    !== {me.op, me.s1, me.s2, me.imm, me.rd}) begin
                failures++;
                $display("FAIL alu1_issue cyc=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", cyc,
                         alu_number[1], iss1_optype, iss1_sr1, iss1_sr2, me.op, me.s1, me.s2);
            end
        end else if (alu_number[1]) begin
            checks++; failures++;
            $display("FAIL alu1_unexpected cyc=%0d got=1 exp=0", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #3;
        chk("rst_alu_number", 64'(alu_number), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_iss0", {iss0_optype, iss0_sr1, iss0_rd_tag}, 64'd0);
        chk("rst_iss1", {iss1_optype, iss1_imm, iss1_rd_tag}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ready ADD issues on ALU0 two edges after dispatch
        disp(4'd1, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7); tick();
        repeat (3) tick();

        // ADDI waits on tag 12, younger XOR ready
        disp(4'd2, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd9); tick();
        disp(4'd3, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22); tick();
        cdb(0, 6'd12, 32'h100); tick();
        repeat (3) tick();

        // three ready entries held, then 2+1 issue, last one on ALU1
        fu_ready = 2'b00;
        disp(4'd1, 1'b1, 6'd0, 32'hA, 1'b1, 6'd0, 32'hB); tick();
        disp(4'd4, 1'b1, 6'd0, 32'hC, 1'b1, 6'd0, 32'hD); tick();
        disp(4'd5, 1'b1, 6'd0, 32'hE, 1'b1, 6'd0, 32'hF); tick();
        tick();
        fu_ready = 2'b11; tick();
        fu_ready = 2'b10; tick();
        fu_ready = 2'b11; repeat (2) tick();

        // fill the queue with waiting loads, overflow dispatch is ignored
        for (int k = 0; k < DEPTH; k++) begin
            disp(4'd8, 1'b0, 6'(20 + k), 32'd0, 1'b1, 6'd0, 32'(k)); tick();
        end
        chk("full_occupancy", 64'(occupancy), 64'd8);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        disp(4'd9, 1'b1, 6'd0, 32'h99, 1'b1, 6'd0, 32'h98); tick();
        cdb(0, 6'd20, 32'h1234); tick();
        tick();
        chk("after_free_disp_ready", 64'(disp_ready), 64'd1);
        for (int k = 1; k < DEPTH; k++) begin cdb(k % 2, 6'(20 + k), 32'(k * 3)); tick(); end
        repeat (3) tick();

        // dispatch bypass from cdb1
        disp(4'd1, 1'b1, 6'd0, 32'd3, 1'b0, 6'd33, 32'd0);
        cdb(1, 6'd33, 32'hDEAD); tick();
        repeat (2) tick();

        // flush with five held entries and a dispatch pending
        fu_ready = 2'b00;
        for (int k = 0; k < 5; k++) begin
            disp(4'd6, 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k + 1)); tick();
        end
        fu_ready = 2'b11; flush = 1'b1;
        disp(4'd7, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2); tick();
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_alu_number", 64'(alu_number), 64'd0);
        repeat (2) tick();

        // async reset while an issue is on the outputs
        disp(4'd1, 1'b1, 6'd0, 32'h55, 1'b1, 6'd0, 32'h66); tick();
        disp(4'd2, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h88); tick();
        #2 rstn = 1'b0;
        #1;
        chk("arst_alu_number", 64'(alu_number), 64'd0);
        chk("arst_iss0", {iss0_optype, iss0_sr1, iss0_rd_tag}, 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_disp_ready", 64'(disp_ready), 64'd1);
        mq.delete(); q0.delete(); q1.delete();
        @(negedge clk);
        rstn = 1'b1;

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) < 6)
                disp(4'($urandom_range(1, 10)), 1'($urandom), 6'($urandom_range(0, 7)), $urandom,
                     1'($urandom), 6'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) == 1) cdb(0, 6'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) == 1) cdb(1, 6'($urandom_range(0, 7)), $urandom);
            fu_ready = 2'($urandom);
            flush = ($urandom_range(0, 39) == 0);
            tick();
        end

        // drain: broadcast every tag so all waiting entries issue
        fu_ready = 2'b11;
        for (int n = 0; n < 40; n++) begin
            cdb(0, 6'(n % 8), $urandom);
            cdb(1, 6'((n + 3) % 8), $urandom);
            tick();
        end
        chk("drain_occupancy", 64'(occupancy), 64'd0);
        chk("drain_q0_left", 64'(q0.size()), 64'd0);
        chk("drain_q1_left", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
